// File: rtl/mx_pkg.sv
// ============================================================================
// mx_pkg : shared MX block geometry (default MXFP6 widths and size helpers)
// Revision: 1.0
// ============================================================================
`default_nettype none

package mx_pkg;

  localparam int MX_EXP_BITS   = 8;
  localparam int MX_ELEM_BITS  = 6;
  localparam int MX_ELEMS      = 32;
  localparam int MX_WORD_BITS  = 32;
  localparam int MX_FIFO_DEPTH = 2;

  function automatic int mx_block_bits(input int k, input int bit_width);
    return MX_EXP_BITS + k * bit_width;
  endfunction

  function automatic int mx_words_per_block(input int k, input int bit_width,
                                            input int word_width);
    return (mx_block_bits(k, bit_width) + word_width - 1) / word_width;
  endfunction

  // Index width that stays legal when only one value is ever needed.
  function automatic int mx_idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mx_block_fifo.sv
// ============================================================================
// mx_block_fifo : depth-entry synchronous block FIFO; a pop frees room for a
//                 same-cycle push when full.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mx_block_fifo
  import mx_pkg::*;
#(
  parameter int DATA_W = 200,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o
);

  localparam int PTR_W = mx_idx_bits(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  always_comb begin
    full_o   = (count_q == CNT_W'(DEPTH));
    pop_ok   = pop_i & (count_q != '0);
    push_ok  = push_i & (~full_o | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data-path only; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/mx_block_packer.sv
// ============================================================================
// mx_block_packer : buffers MX blocks and serialises them into fixed-width
//                   ready/valid words. Option macro MX_PACK_TLAST_EN adds o_last.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mx_block_packer
  import mx_pkg::*;
#(
  parameter int BIT_WIDTH  = MX_ELEM_BITS,
  parameter int K          = MX_ELEMS,
  parameter int WORD_WIDTH = MX_WORD_BITS,
  parameter int DEPTH      = MX_FIFO_DEPTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [BIT_WIDTH-1:0]       i_mx_vec [K],
  input  logic [7:0]                 i_mx_exp,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WORD_WIDTH-1:0]      o_data,
  output logic                       o_first,
  output logic                       o_overflow,
  output logic [$clog2(DEPTH):0]     o_count
`ifdef MX_PACK_TLAST_EN
  ,
  output logic                       o_last
`endif
);

  localparam int B     = mx_block_bits(K, BIT_WIDTH);
  localparam int W     = mx_words_per_block(K, BIT_WIDTH, WORD_WIDTH);
  localparam int IDX_W = mx_idx_bits(W);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [B-1:0]            payload;
  logic [B-1:0]            head;
  logic [W*WORD_WIDTH-1:0] padded;
  logic [WORD_WIDTH-1:0]   words [W];
  logic [CNT_W-1:0]        count;
  logic                    full;
  logic                    handshake;
  logic                    last_word;
  logic                    pop;
  logic                    wr_en;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    overflow_q, overflow_d;

  assign payload[MX_EXP_BITS-1:0] = i_mx_exp;

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_flatten
      assign payload[MX_EXP_BITS + BIT_WIDTH*gi +: BIT_WIDTH] = i_mx_vec[gi];
    end
  endgenerate

  mx_block_fifo #(
    .DATA_W (B),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (wr_en),
    .data_i  (payload),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .full_o  (full)
  );

  always_comb begin
    padded        = '0;
    padded[B-1:0] = head;
  end

  generate
    for (genvar gj = 0; gj < W; gj++) begin : g_words
      assign words[gj] = padded[WORD_WIDTH*gj +: WORD_WIDTH];
    end
  endgenerate

  always_comb begin
    o_valid    = (count != '0);
    handshake  = o_valid & i_ready;
    last_word  = (idx_q == IDX_W'(W - 1));
    pop        = handshake & last_word;
    // A full FIFO still takes a block when the head leaves this same cycle.
    wr_en      = i_valid & (~full | pop);
    overflow_d = overflow_q | (i_valid & ~wr_en);
    idx_d      = idx_q;
    if (handshake) begin
      idx_d = last_word ? '0 : idx_q + 1'b1;
    end
    o_data     = o_valid ? words[idx_q] : '0;
    o_first    = o_valid & (idx_q == '0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_overflow = overflow_q;
  assign o_count    = count;

`ifdef MX_PACK_TLAST_EN
  assign o_last = o_valid & last_word;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mx_block_packer.sv
// ============================================================================
// tb_mx_block_packer : directed self-checking bench for mx_block_packer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mx_block_packer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [5:0]  mx_vec [32];
  logic [7:0]  i_mx_exp;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic        o_first;
  logic        o_overflow;
  logic [1:0]  o_count;
`ifdef MX_PACK_TLAST_EN
  logic        o_last;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] blk_exp [12];
  logic [5:0] blk_el  [12][32];

  always #5 i_clk = ~i_clk;

  mx_block_packer dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .i_mx_vec   (mx_vec),
    .i_mx_exp   (i_mx_exp),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_first    (o_first),
    .o_overflow (o_overflow),
    .o_count    (o_count)
`ifdef MX_PACK_TLAST_EN
    ,
    .o_last     (o_last)
`endif
  );

  // Bit-by-bit golden layout: exponent in bits 0..7, element e at 8+6e, zero pad.
  function automatic logic [31:0] model_word(input int b, input int j);
    logic [31:0] w;
    int p;
    w = '0;
    for (int t = 0; t < 32; t++) begin
      p = 32*j + t;
      if (p < 8)        w[t] = blk_exp[b][p];
      else if (p < 200) w[t] = blk_el[b][(p-8)/6][(p-8)%6];
    end
    return w;
  endfunction

  task automatic put_block(input int b);
    i_valid  = 1'b1;
    i_mx_exp = blk_exp[b];
    for (int i = 0; i < 32; i++) mx_vec[i] = blk_el[b][i];
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    n_tests++;
    if (o_valid !== 1'b0 || o_count !== 2'd0 || o_overflow !== 1'b0 ||
        o_first !== 1'b0 || o_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b c=%0d ov=%b f=%b d=%h exp 0 0 0 0 0",
               o_valid, o_count, o_overflow, o_first, o_data);
    end
`ifdef MX_PACK_TLAST_EN
    n_tests++;
    if (o_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_last got %b exp 0", o_last);
    end
`endif
    i_rst_n = 1'b1;
    @(negedge i_clk);
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset o_valid got %b exp 0", o_valid);
    end
  endtask

  task automatic test_all_ones();
    logic [31:0] exp_w;
    i_ready = 1'b1;
    put_block(0);
    @(negedge i_clk);
    i_valid = 1'b0;
    for (int j = 0; j < 7; j++) begin
      exp_w = (j == 0) ? 32'hFFFFFF7F : (j == 6) ? 32'h000000FF : 32'hFFFFFFFF;
      n_tests++;
      if (o_valid !== 1'b1 || o_data !== exp_w || o_first !== (j == 0)) begin
        n_fail++;
        $display("FAIL ones_word%0d got v=%b d=%h f=%b exp v=1 d=%h f=%b",
                 j, o_valid, o_data, o_first, exp_w, (j == 0));
      end
`ifdef MX_PACK_TLAST_EN
      n_tests++;
      if (o_last !== (j == 6)) begin
        n_fail++;
        $display("FAIL ones_last%0d got %b exp %b", j, o_last, (j == 6));
      end
`endif
      @(negedge i_clk);
    end
    n_tests++;
    if (o_valid !== 1'b0 || o_count !== 2'd0) begin
      n_fail++;
      $display("FAIL ones_drained got v=%b c=%0d exp v=0 c=0", o_valid, o_count);
    end
  endtask

  task automatic test_ramp();
    i_ready = 1'b1;
    put_block(1);
    @(negedge i_clk);
    i_valid = 1'b0;
    n_tests++;
    if (o_data !== 32'h0C204000 || o_first !== 1'b1 || o_count !== 2'd1) begin
      n_fail++;
      $display("FAIL ramp_word0 got d=%h f=%b c=%0d exp d=0c204000 f=1 c=1",
               o_data, o_first, o_count);
    end
    for (int j = 0; j < 7; j++) begin
      n_tests++;
      if (o_valid !== 1'b1 || o_data !== model_word(1, j)) begin
        n_fail++;
        $display("FAIL ramp_word%0d got v=%b d=%h exp v=1 d=%h",
                 j, o_valid, o_data, model_word(1, j));
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_overflow();
    int rx;
    do_reset();
    put_block(2);
    @(negedge i_clk);
    put_block(3);
    @(negedge i_clk);
    put_block(4);
    @(negedge i_clk);
    i_valid = 1'b0;
    n_tests++;
    if (o_count !== 2'd2 || o_overflow !== 1'b1 || o_data !== model_word(2, 0)) begin
      n_fail++;
      $display("FAIL ovf_state got c=%0d ov=%b d=%h exp c=2 ov=1 d=%h",
               o_count, o_overflow, o_data, model_word(2, 0));
    end
    @(negedge i_clk);
    n_tests++;
    if (o_data !== model_word(2, 0) || o_first !== 1'b1 || o_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_hold got d=%h f=%b ov=%b exp d=%h f=1 ov=1",
               o_data, o_first, o_overflow, model_word(2, 0));
    end
    i_ready = 1'b1;
    rx = 0;
    for (int c = 0; c < 40 && o_valid === 1'b1; c++) begin
      n_tests++;
      if (rx >= 14 || o_data !== model_word(2 + rx/7, rx%7) || o_first !== (rx%7 == 0)) begin
        n_fail++;
        $display("FAIL ovf_word%0d got d=%h f=%b exp d=%h f=%b",
                 rx, o_data, o_first, model_word(2 + (rx%14)/7, rx%7), (rx%7 == 0));
      end
      rx++;
      @(negedge i_clk);
    end
    n_tests++;
    if (rx !== 14 || o_overflow !== 1'b1 || o_count !== 2'd0) begin
      n_fail++;
      $display("FAIL ovf_drain got words=%0d ov=%b c=%0d exp words=14 ov=1 c=0",
               rx, o_overflow, o_count);
    end
  endtask

  task automatic test_full_pop_push();
    do_reset();
    put_block(5);
    @(negedge i_clk);
    put_block(6);
    @(negedge i_clk);
    i_valid = 1'b0;
    n_tests++;
    if (o_count !== 2'd2) begin
      n_fail++;
      $display("FAIL full_count got %0d exp 2", o_count);
    end
    i_ready = 1'b1;
    for (int j = 0; j < 7; j++) begin
      n_tests++;
      if (o_data !== model_word(5, j)) begin
        n_fail++;
        $display("FAIL full_head_word%0d got %h exp %h", j, o_data, model_word(5, j));
      end
      if (j == 6) put_block(7);
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    n_tests++;
    if (o_overflow !== 1'b0 || o_count !== 2'd2 || o_first !== 1'b1 ||
        o_data !== model_word(6, 0)) begin
      n_fail++;
      $display("FAIL full_popush got ov=%b c=%0d f=%b d=%h exp ov=0 c=2 f=1 d=%h",
               o_overflow, o_count, o_first, o_data, model_word(6, 0));
    end
    for (int r = 0; r < 14; r++) begin
      n_tests++;
      if (o_valid !== 1'b1 || o_data !== model_word(6 + r/7, r%7)) begin
        n_fail++;
        $display("FAIL full_tail_word%0d got v=%b d=%h exp v=1 d=%h",
                 r, o_valid, o_data, model_word(6 + r/7, r%7));
      end
      @(negedge i_clk);
    end
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drained o_valid got %b exp 0", o_valid);
    end
  endtask

  task automatic test_random_stall();
    int rx;
    int pushed;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_first;
    do_reset();
    rx = 0;
    pushed = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_first = 1'b0;
    for (int c = 0; c < 400 && rx < 28; c++) begin
      if (prev_stall) begin
        n_tests++;
        if (o_valid !== 1'b1 || o_data !== prev_data || o_first !== prev_first) begin
          n_fail++;
          $display("FAIL stall_hold cyc=%0d got v=%b d=%h f=%b exp v=1 d=%h f=%b",
                   c, o_valid, o_data, o_first, prev_data, prev_first);
        end
      end
      i_valid = 1'b0;
      if (pushed < 4 && o_count < 2'd2) begin
        put_block(8 + pushed);
        pushed++;
      end
      i_ready = ($urandom_range(0, 1) == 1);
      if (o_valid === 1'b1) begin
        n_tests++;
        if (o_data !== model_word(8 + rx/7, rx%7) || o_first !== (rx%7 == 0)) begin
          n_fail++;
          $display("FAIL stall_word%0d got d=%h f=%b exp d=%h f=%b",
                   rx, o_data, o_first, model_word(8 + rx/7, rx%7), (rx%7 == 0));
        end
        if (i_ready) rx++;
      end
      prev_stall = o_valid & ~i_ready;
      prev_data  = o_data;
      prev_first = o_first;
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    n_tests++;
    if (rx !== 28 || o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_total got words=%0d ov=%b exp words=28 ov=0", rx, o_overflow);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    i_ready = 1'b1;
    put_block(9);
    @(negedge i_clk);
    i_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (o_data !== model_word(9, j)) begin
        n_fail++;
        $display("FAIL midrst_pre_word%0d got %h exp %h", j, o_data, model_word(9, j));
      end
      if (j == 3) i_rst_n = 1'b0;
      @(negedge i_clk);
    end
    n_tests++;
    if (o_valid !== 1'b0 || o_count !== 2'd0 || o_first !== 1'b0 || o_data !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_state got v=%b c=%0d f=%b d=%h exp 0 0 0 0",
               o_valid, o_count, o_first, o_data);
    end
    i_rst_n = 1'b1;
    put_block(10);
    @(negedge i_clk);
    i_valid = 1'b0;
    for (int j = 0; j < 7; j++) begin
      n_tests++;
      if (o_valid !== 1'b1 || o_data !== model_word(10, j) || o_first !== (j == 0)) begin
        n_fail++;
        $display("FAIL midrst_word%0d got v=%b d=%h f=%b exp v=1 d=%h f=%b",
                 j, o_valid, o_data, o_first, model_word(10, j), (j == 0));
      end
`ifdef MX_PACK_TLAST_EN
      n_tests++;
      if (o_last !== (j == 6)) begin
        n_fail++;
        $display("FAIL midrst_last%0d got %b exp %b", j, o_last, (j == 6));
      end
`endif
      @(negedge i_clk);
    end
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_drained o_valid got %b exp 0", o_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_mx_exp = '0;
    for (int i = 0; i < 32; i++) mx_vec[i] = '0;
    blk_exp[0] = 8'h7F;
    blk_exp[1] = 8'h00;
    for (int i = 0; i < 32; i++) begin
      blk_el[0][i] = 6'h3F;
      blk_el[1][i] = 6'(i);
    end
    for (int b = 2; b < 12; b++) begin
      blk_exp[b] = 8'($urandom);
      for (int i = 0; i < 32; i++) blk_el[b][i] = 6'($urandom);
    end

    test_reset();
    test_all_ones();
    test_ramp();
    test_overflow();
    test_full_pop_push();
    test_random_stall();
    test_mid_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
